// File: rtl/phy_rx_deskew_ctrl_if.sv
// Lane-side bus of the two-lane receive deskew controller: raw lane bytes in,
// aligned lane bytes and alignment status out.
interface phy_rx_deskew_ctrl_if #(
    parameter int SKW_W = 2
);
    logic             active0;
    logic             active1;
    logic [7:0]       data_in0;
    logic             valid_in0;
    logic [7:0]       data_in1;
    logic             valid_in1;
    logic [7:0]       data_out0;
    logic             valid_out0;
    logic [7:0]       data_out1;
    logic             valid_out1;
    logic             aligned;
    logic             skew_err;
    logic [SKW_W-1:0] skew_val;
    logic             late_lane;

    modport master (
        output active0, active1, data_in0, valid_in0, data_in1, valid_in1,
        input  data_out0, valid_out0, data_out1, valid_out1,
        input  aligned, skew_err, skew_val, late_lane
    );

    modport slave (
        input  active0, active1, data_in0, valid_in0, data_in1, valid_in1,
        output data_out0, valid_out0, data_out1, valid_out1,
        output aligned, skew_err, skew_val, late_lane
    );
endinterface

// File: rtl/phy_rx_deskew_ctrl.sv
// Two-lane receive deskew: measures the byte-cycle skew between the first valid
// byte on each lane, then delays the early lane so both lanes leave aligned.
module phy_rx_deskew_ctrl #(
    parameter int MAX_SKEW = 3,
    parameter int SKW_W    = 2
) (
    input  logic                   clk_4f,
    input  logic                   reset,
    phy_rx_deskew_ctrl_if.slave    io
);
    typedef enum logic [1:0] {IDLE, MEASURE, ALIGNED, ERROR} state_e;

    state_e           state_q, state_d;
    logic [1:0]       seen_q, seen_d;
    logic [SKW_W-1:0] cnt_q, cnt_d;
    logic [SKW_W-1:0] skew_q, skew_d;
    logic             late_q, late_d;

    logic             both_act;
    logic [1:0]       hit;
    logic             pend_lane;
    logic             dl_clr;
    logic [1:0][8:0]  in_vd;
    logic [1:0][8:0]  out_vd;

    assign both_act  = io.active0 & io.active1;
    assign hit       = {io.valid_in1, io.valid_in0};
    // With exactly one lane seen, the other one is the lane still pending.
    assign pend_lane = seen_q[0];
    assign dl_clr    = (state_q == ALIGNED) && !both_act;
    assign in_vd[0]  = {io.valid_in0, io.data_in0};
    assign in_vd[1]  = {io.valid_in1, io.data_in1};

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q <= IDLE;
            seen_q  <= '0;
            cnt_q   <= '0;
            skew_q  <= '0;
            late_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
            cnt_q   <= cnt_d;
            skew_q  <= skew_d;
            late_q  <= late_d;
        end
    end

    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        cnt_d   = cnt_q;
        skew_d  = skew_q;
        late_d  = late_q;
        unique case (state_q)
            IDLE: begin
                seen_d = '0;
                cnt_d  = '0;
                skew_d = '0;
                late_d = 1'b0;
                if (both_act) state_d = MEASURE;
            end
            MEASURE: begin
                if (!both_act) begin
                    state_d = IDLE;
                end else if (seen_q == 2'b00) begin
                    if (&hit) begin
                        skew_d  = '0;
                        late_d  = 1'b0;
                        state_d = ALIGNED;
                    end else begin
                        seen_d = hit;
                    end
                end else if (hit[pend_lane]) begin
                    skew_d  = SKW_W'(cnt_q + 1'b1);
                    late_d  = pend_lane;
                    state_d = ALIGNED;
                end else if (cnt_q == SKW_W'(MAX_SKEW - 1)) begin
                    // Next byte would exceed the delay line depth.
                    state_d = ERROR;
                end else begin
                    cnt_d = SKW_W'(cnt_q + 1'b1);
                end
            end
            ALIGNED: begin
                if (!both_act) begin
                    state_d = IDLE;
                    skew_d  = '0;
                    late_d  = 1'b0;
                end
            end
            ERROR: begin
                if (!io.active0 && !io.active1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar l = 0; l < 2; l++) begin : g_lane
        localparam bit LANE = (l == 1);

        logic [MAX_SKEW:1][8:0] dl_q;
        logic [MAX_SKEW:0][8:0] tap;
        logic [SKW_W-1:0]       sel;
        logic [8:0]             out_q;

        assign tap = {dl_q, in_vd[l]};
        // Next-state skew/late are used so the entry edge already aligns.
        assign sel = (late_d == LANE) ? '0 : skew_d;

        always_ff @(posedge clk_4f) begin
            if (reset || dl_clr) begin
                dl_q <= '0;
            end else begin
                for (int k = MAX_SKEW; k > 1; k--) dl_q[k] <= dl_q[k-1];
                dl_q[1] <= in_vd[l];
            end
        end

        always_ff @(posedge clk_4f) begin
            if (reset || state_d != ALIGNED) out_q <= '0;
            else                              out_q <= tap[sel];
        end

        assign out_vd[l] = out_q;
    end

    assign {io.valid_out0, io.data_out0} = out_vd[0];
    assign {io.valid_out1, io.data_out1} = out_vd[1];
    assign io.aligned   = (state_q == ALIGNED);
    assign io.skew_err  = (state_q == ERROR);
    assign io.skew_val  = skew_q;
    assign io.late_lane = late_q;
endmodule

// File: doc/phy_rx_deskew_ctrl.md
Name: phy_rx_deskew_ctrl

Overview:
Lane-alignment controller for the two-lane PHY receiver, sitting between the two serial-to-parallel converters and the 8:32 muxes. It replaces the fixed two-cycle delay on lane 1 with a measured, per-lane programmable delay. After both lanes go active it measures the byte-cycle skew between the first valid byte on each lane, then delays the early lane so that both lanes present aligned bytes downstream. It reports alignment state and skew errors.

Parameters:
MAX_SKEW, 3, maximum correctable skew in clk_4f cycles; depth of each delay line.
SKW_W, 2, width of skew/delay values; must satisfy 2^SKW_W > MAX_SKEW.

Ports:
clk_4f  input  1  byte clock; the only clock.
reset  input  1  synchronous, active-high reset.
active0  input  1  lane 0 active from serial-to-parallel.
active1  input  1  lane 1 active from serial-to-parallel.
data_in0  input  8  lane 0 byte.
valid_in0  input  1  lane 0 byte valid.
data_in1  input  8  lane 1 byte.
valid_in1  input  1  lane 1 byte valid.
data_out0  output  8  aligned lane 0 byte, to mux8_32 lane 0.
valid_out0  output  1  aligned lane 0 valid.
data_out1  output  8  aligned lane 1 byte, to mux8_32 lane 1.
valid_out1  output  1  aligned lane 1 valid.
aligned  output  1  1 while in ALIGNED.
skew_err  output  1  1 while in ERROR.
skew_val  output  SKW_W  measured skew; meaningful when aligned=1.
late_lane  output  1  0 = lane 0 arrived last, 1 = lane 1 arrived last; meaningful when aligned=1.

Behaviour:
- Single clock domain, clk_4f. Reset is synchronous and active-high. Every register clears on reset.
- Reset values: all data/valid outputs = 0, aligned = 0, skew_err = 0, skew_val = 0, late_lane = 0. Delay lines = 0. FSM state = IDLE.
- Delay lines: one per lane. Each is a shift register of MAX_SKEW entries of {valid, data}. They shift every cycle in every state.
  - tap[0] is the current input; tap[k] is the input from k cycles earlier.
- FSM states: IDLE, MEASURE, ALIGNED, ERROR.
- IDLE:
  - Outputs are 0 and the skew counter is 0.
  - Go to MEASURE when active0 & active1.
- MEASURE:
  - Seen flags seen0/seen1 are cleared on entry.
  - A lane is "seen" in the first cycle in MEASURE where its valid_in = 1. A valid already high on entry counts.
  - Both lanes seen in the same cycle: skew = 0 and late_lane = 0. Go to ALIGNED.
  - One lane seen first: the counter increments each following cycle.
  - The other lane seen with counter = c: skew = c + 1. The late lane is that lane. Go to ALIGNED.
  - Counter reaches MAX_SKEW with the late lane still not valid in that cycle: go to ERROR.
  - Either active drops: go to IDLE.
- ALIGNED (including the transition edge into it):
  - Late lane: data_out/valid_out register tap[0].
  - Early lane: data_out/valid_out register tap[skew].
  - Resulting latency: late lane 1 cycle, early lane 1 + skew cycles.
  - The first aligned pair is the first byte of each lane, and it appears together one cycle after the late lane is seen.
  - skew_val and late_lane are held.
  - aligned = 1 from the cycle after the transition edge.
  - Either active drops: go to IDLE. Outputs go to 0 on that same edge and the delays clear.
- ERROR:
  - skew_err = 1 and outputs are 0.
  - Stay in ERROR until active0 = 0 and active1 = 0, then go to IDLE.
- Outside ALIGNED (and its entry edge), data_out*/valid_out* = 0.
- Reset mid-operation returns to IDLE on the next edge, whatever the state.
- Re-alignment requires passing through IDLE (an active drop).

Test Plan:
1. Reset held 2 cycles with active0 = active1 = 1 and valid pulses on both lanes → all outputs 0, state stays IDLE. Deassert reset → MEASURE on the next cycle.
2. Both lanes go valid in the same cycle, lane0 = 0xA1, lane1 = 0xB1 → skew_val = 0 and aligned = 1. 0xA1 and 0xB1 appear together with latency 1 cycle.
3. Lane1 first valid = 0xB1 at cycle t, lane0 first valid = 0xA1 at cycle t+2 → skew_val = 2 and late_lane = 0. 0xA1 and 0xB1 appear together at cycle t+3. Lane1 latency = 3 cycles thereafter.
4. Lane0 valid at t, lane1 valid at t+3 with MAX_SKEW = 3 → skew_val = 3 and late_lane = 1, aligned. Repeat with lane1 valid at t+4 → skew_err = 1 at t+4 and outputs 0. Drop both actives → IDLE.
5. In ALIGNED, active1 drops for 1 cycle → outputs 0 next cycle and aligned = 0. Restore active1 → MEASURE re-entered and a new skew is measured.
6. Reset asserted in the middle of ALIGNED while streaming → outputs 0, aligned = 0, skew_val = 0 on the next edge.
